// File: rtl/axis_camlink_frame_rx_if.sv
// -----------------------------------------------------------------------------
// axis_camlink_frame_rx_if
// AXI4-Stream style pixel output bundle used by axis_camlink_frame_rx.
//   tdata  : pixel beat (DATA_WIDTH bits)
//   tvalid : beat available
//   tready : consumer accepts beat
//   tlast  : last beat of a video line
//   tuser  : first beat of a video frame
// -----------------------------------------------------------------------------
interface axis_camlink_frame_rx_if #(
    parameter int DATA_WIDTH = 24
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic                  tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, input  tuser, output tready);
endinterface

// File: rtl/axis_camlink_frame_rx.sv
// -----------------------------------------------------------------------------
// axis_camlink_frame_rx
// Converts parsed CameraLink FVAL/LVAL/DVAL video into an AXI4-Stream with
// tuser = start of frame and tlast = end of line, buffered in a FIFO.
// Ports:
//   axis_clk, rst            : clock, synchronous active-high reset
//   cam_fval/lval/dval       : frame / line / data valid from the deserializer
//   cam_data                 : pixel beat, port A in [7:0]
//   m_axis                   : stream output (master modport)
//   stat_clear               : pulse clearing overflow and drop_count
//   frame_width/frame_height : beats in last line / lines in last frame
//   overflow, drop_count     : sticky overflow flag, saturating dropped frames
// -----------------------------------------------------------------------------
module axis_camlink_frame_rx #(
    parameter int DATA_WIDTH = 24,
    parameter int FIFO_DEPTH = 512,
    parameter bit DVAL_EN    = 1'b1
) (
    input  logic                    axis_clk,
    input  logic                    rst,
    input  logic                    cam_fval,
    input  logic                    cam_lval,
    input  logic                    cam_dval,
    input  logic [DATA_WIDTH-1:0]   cam_data,
    axis_camlink_frame_rx_if.master m_axis,
    input  logic                    stat_clear,
    output logic [15:0]             frame_width,
    output logic [15:0]             frame_height,
    output logic                    overflow,
    output logic [7:0]              drop_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_WIDTH + 2;   // {tlast, tuser, tdata}

    typedef enum logic [1:0] {IDLE, WAIT_LINE, LINE, DROP} state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // ---------------- input register stage ----------------
    logic                  fval_q, fval_prev_q, lval_q, lval_prev_q, dval_q;
    logic [DATA_WIDTH-1:0] data_q;

    // FVAL history resets high so a frame already running at reset exit
    // never produces a rising edge.
    always_ff @(posedge axis_clk) begin
        if (rst) begin
            fval_q      <= 1'b1;
            fval_prev_q <= 1'b1;
            lval_q      <= 1'b0;
            lval_prev_q <= 1'b0;
            dval_q      <= 1'b0;
            data_q      <= '0;
        end else begin
            fval_q      <= cam_fval;
            fval_prev_q <= fval_q;
            lval_q      <= cam_lval;
            lval_prev_q <= lval_q;
            dval_q      <= cam_dval;
            data_q      <= cam_data;
        end
    end

    logic fval_rise, fval_fall, lval_rise, lval_fall;
    assign fval_rise = fval_q & ~fval_prev_q;
    assign fval_fall = ~fval_q & fval_prev_q;
    assign lval_rise = lval_q & ~lval_prev_q;
    assign lval_fall = ~lval_q & lval_prev_q;

    // ---------------- frame FSM / holdback ----------------
    state_e                state_q, state_d;
    logic                  hb_valid_q, hb_valid_d;
    logic [DATA_WIDTH-1:0] hb_data_q, hb_data_d;
    logic                  sof_q, sof_d;
    logic [15:0]           beats_q, beats_d, lines_q, lines_d;
    logic [15:0]           width_q, width_d, height_q, height_d;
    logic                  overflow_q;
    logic [7:0]            drop_q;

    logic                  wr_pend_q;
    logic [EW-1:0]         wr_data_q;
    logic [AW:0]           count_q;
    logic [AW+1:0]         occ_sum;
    logic                  full_eff;

    // The first beat of a line is registered in the same cycle the LVAL
    // edge is seen, so line_start lets it be accepted before LINE is entered.
    logic line_start, in_line, acc, close;
    assign line_start = lval_rise & ((state_q == WAIT_LINE) | ((state_q == IDLE) & fval_rise));
    assign in_line    = (state_q == LINE) | line_start;
    assign acc        = in_line & fval_q & lval_q & (dval_q | ~DVAL_EN);
    assign close      = (state_q == LINE) & (lval_fall | fval_fall);

    // A push is registered one cycle before it lands in the FIFO, so the
    // pending write is counted when deciding whether there is room.
    assign occ_sum  = {1'b0, count_q} + {{(AW+1){1'b0}}, wr_pend_q};
    assign full_eff = occ_sum >= (AW+2)'(FIFO_DEPTH);

    logic push_req, push_ok, ovf_evt;
    assign push_req = hb_valid_q & (acc | close);

    always_comb begin
        state_d    = state_q;
        hb_valid_d = hb_valid_q;
        hb_data_d  = hb_data_q;
        sof_d      = sof_q;
        beats_d    = beats_q;
        lines_d    = lines_q;
        width_d    = width_q;
        height_d   = height_q;
        push_ok    = 1'b0;
        ovf_evt    = 1'b0;

        if (push_req && full_eff) begin
            // Beat lost: abandon the rest of the frame.
            ovf_evt    = 1'b1;
            hb_valid_d = 1'b0;
            beats_d    = '0;
            state_d    = fval_fall ? IDLE : DROP;
        end else begin
            push_ok = push_req;
            if (push_req) sof_d = 1'b0;
            if (acc) begin
                hb_valid_d = 1'b1;
                hb_data_d  = data_q;
                beats_d    = sat_inc16(beats_q);
            end
            if (close) begin
                hb_valid_d = 1'b0;
                beats_d    = '0;
                if (hb_valid_q) begin
                    width_d = beats_q;
                    lines_d = sat_inc16(lines_q);
                end
            end
            case (state_q)
                IDLE: if (fval_rise) begin
                    state_d = line_start ? LINE : WAIT_LINE;
                    sof_d   = 1'b1;
                    lines_d = '0;
                end
                WAIT_LINE: begin
                    if (fval_fall) begin
                        state_d  = IDLE;
                        height_d = lines_q;
                    end else if (lval_rise) begin
                        state_d = LINE;
                    end
                end
                LINE: begin
                    if (fval_fall) begin
                        state_d  = IDLE;
                        height_d = lines_d;   // includes a line closed this cycle
                    end else if (lval_fall) begin
                        state_d = WAIT_LINE;
                    end
                end
                DROP: if (fval_fall) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge axis_clk) begin
        if (rst) begin
            state_q    <= IDLE;
            hb_valid_q <= 1'b0;
            hb_data_q  <= '0;
            sof_q      <= 1'b0;
            beats_q    <= '0;
            lines_q    <= '0;
            width_q    <= '0;
            height_q   <= '0;
            wr_pend_q  <= 1'b0;
            wr_data_q  <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            hb_valid_q <= hb_valid_d;
            hb_data_q  <= hb_data_d;
            sof_q      <= sof_d;
            beats_q    <= beats_d;
            lines_q    <= lines_d;
            width_q    <= width_d;
            height_q   <= height_d;
            wr_pend_q  <= push_ok;
            wr_data_q  <= {close, sof_q, hb_data_q};
            // A new overflow outranks a simultaneous clear.
            if (ovf_evt) begin
                overflow_q <= 1'b1;
                drop_q     <= stat_clear ? 8'd1 : ((drop_q == 8'hFF) ? drop_q : drop_q + 8'd1);
            end else if (stat_clear) begin
                overflow_q <= 1'b0;
                drop_q     <= '0;
            end
        end
    end

    // ---------------- output FIFO ----------------
    logic [EW-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic          wr_en, pop, not_empty;
    logic [EW-1:0] head;

    assign not_empty = (count_q != '0);
    assign wr_en     = wr_pend_q & (count_q != (AW+1)'(FIFO_DEPTH));
    assign pop       = not_empty & m_axis.tready;
    assign head      = fifo_mem[rd_ptr_q];

    always_ff @(posedge axis_clk) begin
        if (wr_en) fifo_mem[wr_ptr_q] <= wr_data_q;
    end

    always_ff @(posedge axis_clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Memory contents are undefined after reset; gate the flags with tvalid.
    assign m_axis.tvalid = not_empty;
    assign m_axis.tdata  = head[DATA_WIDTH-1:0];
    assign m_axis.tuser  = not_empty & head[DATA_WIDTH];
    assign m_axis.tlast  = not_empty & head[DATA_WIDTH+1];

    assign frame_width  = width_q;
    assign frame_height = height_q;
    assign overflow     = overflow_q;
    assign drop_count   = drop_q;
endmodule
